// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one variable-latency memory port between instruction
//               fetch and data load/store, with a per-transaction timeout and
//               sticky error flag. Optional IF anti-starvation:
//               MEM_ARB_FAIRNESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_l,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_done,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_done,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LIMIT = TCNT_W'(TIMEOUT_CYCLES);
    localparam logic [DATA_W-1:0] IF_NOP     = DATA_W'(32'h0000_0013);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [1:0]        state_q, state_d;
    logic              owner_d_q, owner_d_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;

    logic w_force_if;
    logic w_grant_d;
    logic w_grant_if;

    assign w_grant_d  = (state_q == S_IDLE) && i_d_req && !w_force_if;
    assign w_grant_if = (state_q == S_IDLE) && i_if_req && !w_grant_d;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int SCNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LIMIT = SCNT_W'(STARVE_LIMIT);

    logic [SCNT_W-1:0] starve_q, starve_d;

    assign w_force_if = i_if_req && i_d_req && (starve_q == SCNT_LIMIT);

    // Counts D grants that jumped a waiting fetch; only evaluated in IDLE.
    always_comb begin
        starve_d = starve_q;
        if (state_q == S_IDLE) begin
            if (!i_if_req || w_grant_if) begin
                starve_d = '0;
            end else if (w_grant_d && (starve_q != SCNT_LIMIT)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict data priority: the starvation limit has no effect in this build.
    assign w_force_if = (STARVE_LIMIT < 0);
`endif

    always_comb begin
        state_d     = state_q;
        owner_d_d   = owner_d_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;
        tcnt_d      = tcnt_q;

        case (state_q)
            S_IDLE: begin
                if (w_grant_d || w_grant_if) begin
                    owner_d_d   = w_grant_d;
                    mem_we_d    = w_grant_d & i_d_we;
                    mem_addr_d  = (w_grant_d ? i_d_addr : i_if_addr) & ALIGN_MASK;
                    mem_wdata_d = w_grant_d ? i_d_wdata : '0;
                    mem_req_d   = 1'b1;
                    tcnt_d      = '0;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (i_mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                    if_done_d = !owner_d_q;
                    d_done_d  = owner_d_q;
                    if (!mem_we_q) begin
                        if (owner_d_q) begin
                            d_rdata_d = i_mem_rdata;
                        end else begin
                            if_rdata_d = i_mem_rdata;
                        end
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                    // Abandon the access; fetch gets a nop so the core keeps going.
                    if ((TIMEOUT_CYCLES != 0) && (tcnt_d == TCNT_LIMIT)) begin
                        mem_req_d = 1'b0;
                        err_d     = 1'b1;
                        state_d   = S_RESP;
                        if_done_d = !owner_d_q;
                        d_done_d  = owner_d_q;
                        if (owner_d_q) begin
                            d_rdata_d = '0;
                        end else begin
                            if_rdata_d = IF_NOP;
                        end
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            state_q     <= S_IDLE;
            owner_d_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_d_q   <= owner_d_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign o_if_done   = if_done_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_d_done    = d_done_q;
    assign o_d_rdata   = d_rdata_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed and random
//               transactions against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int TO   = 8;
    localparam int SLIM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_done;
    logic [31:0] o_if_rdata;
    logic        i_d_req;
    logic        i_d_we;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic        o_d_done;
    logic [31:0] o_d_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_err;

    mem_port_arbiter #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(TO),
        .STARVE_LIMIT  (SLIM)
    ) dut (
        .i_clk      (clk),
        .i_rst_l    (rst_n),
        .i_if_req   (i_if_req),
        .i_if_addr  (i_if_addr),
        .o_if_done  (o_if_done),
        .o_if_rdata (o_if_rdata),
        .i_d_req    (i_d_req),
        .i_d_we     (i_d_we),
        .i_d_addr   (i_d_addr),
        .i_d_wdata  (i_d_wdata),
        .o_d_done   (o_d_done),
        .o_d_rdata  (o_d_rdata),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_ack  (i_mem_ack),
        .i_mem_rdata(i_mem_rdata),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] phys_mem [0:255];
    logic [31:0] ref_mem  [0:255];
    int          ack_delay;
    bit          ack_en;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
    logic        exp_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Memory: acks ack_delay cycles after o_mem_req rises, garbage rdata otherwise.
    initial begin : memory
        int busy_cnt;
        busy_cnt    = 0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            i_mem_ack = 1'b0;
            if (o_mem_req) begin
                if (ack_en && busy_cnt == ack_delay) begin
                    i_mem_ack = 1'b1;
                    if (o_mem_we) phys_mem[o_mem_addr[9:2]] = o_mem_wdata;
                    else          i_mem_rdata = phys_mem[o_mem_addr[9:2]];
                end else begin
                    i_mem_rdata = $urandom;
                end
                busy_cnt++;
            end else begin
                busy_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // One request (or an IF+D pair raised together) carried through to its done pulse(s).
    task automatic run_txn(input bit use_if, input bit use_d, input logic [31:0] ia,
                           input logic [31:0] da, input bit dwe, input logic [31:0] dwd,
                           input bit tmo);
        logic [31:0] q_addr[$];
        bit          q_we[$];
        logic [31:0] q_wd[$];
        int          if_n, d_n, rise_cyc, last_done, req_len, grants, lat;
        bit          prev_req, exp_we, extra;
        logic [31:0] wd;
        if_n = 0; d_n = 0; rise_cyc = 0; last_done = 0; req_len = 0; grants = 0;
        prev_req = 1'b0; extra = 1'b0;
        lat = tmo ? TO : ack_delay + 1;
        // Data is served before fetch; a store is visible to the fetch that follows.
        if (use_d) begin
            q_addr.push_back(da & 32'hFFFF_FFFC);
            q_we.push_back(dwe);
            q_wd.push_back(dwd);
            if (tmo)      exp_d_rdata = '0;
            else if (dwe) ref_mem[da[9:2]] = dwd;
            else          exp_d_rdata = ref_mem[da[9:2]];
        end
        if (use_if) begin
            q_addr.push_back(ia & 32'hFFFF_FFFC);
            q_we.push_back(1'b0);
            q_wd.push_back('0);
            exp_if_rdata = tmo ? 32'h0000_0013 : ref_mem[ia[9:2]];
        end
        if (tmo) exp_err = 1'b1;

        i_if_req  = use_if;
        i_if_addr = ia;
        i_d_req   = use_d;
        i_d_we    = dwe;
        i_d_addr  = da;
        i_d_wdata = dwd;
        for (int cyc = 1; cyc <= 80 && (if_n < int'(use_if) || d_n < int'(use_d)); cyc++) begin
            @(posedge clk);
            #1;
            if (o_mem_req && !prev_req) begin
                grants++;
                if (grants == 1) check("first grant cycle", 64'(cyc), 64'(1));
                else             check("second grant cycle", 64'(cyc), 64'(last_done + 2));
                if (q_addr.size() == 0) begin
                    check("unexpected grant", 64'(grants), 64'(int'(use_if) + int'(use_d)));
                end else begin
                    check("grant addr", 64'(o_mem_addr), 64'(q_addr.pop_front()));
                    exp_we = q_we.pop_front();
                    wd     = q_wd.pop_front();
                    check("grant we", 64'(o_mem_we), 64'(exp_we));
                    if (exp_we) check("grant wdata", 64'(o_mem_wdata), 64'(wd));
                end
                rise_cyc = cyc;
                req_len  = 0;
            end
            if (o_mem_req) req_len++;
            if (tmo && prev_req && !o_mem_req) check("timeout req length", 64'(req_len), 64'(TO));
            if (o_if_done || o_d_done) begin
                check("done latency", 64'(cyc - rise_cyc), 64'(lat));
                last_done = cyc;
            end
            if (o_if_done) begin
                if_n++;
                check("if rdata", 64'(o_if_rdata), 64'(exp_if_rdata));
                i_if_req = 1'b0;
            end
            if (o_d_done) begin
                d_n++;
                check("d rdata", 64'(o_d_rdata), 64'(exp_d_rdata));
                i_d_req = 1'b0;
            end
            prev_req = o_mem_req;
        end
        check("if done count", 64'(if_n), 64'(int'(use_if)));
        check("d done count", 64'(d_n), 64'(int'(use_d)));
        i_if_req = 1'b0;
        i_d_req  = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            extra = extra | o_if_done | o_d_done | o_mem_req;
        end
        check("quiet after txn", 64'(extra), 64'(0));
        check("err flag", 64'(o_err), 64'(exp_err));
    endtask

    initial begin : stimulus
        logic [31:0] w, ra, rb, rwd;
        bit          rwe;
        int          kind, n, starve;
        logic [4:0]  seq, exp_seq;
        bit          prev, quiet;
        bit          fair;

        rst_n     = 1'b0;
        i_if_req  = 1'b0;
        i_if_addr = '0;
        i_d_req   = 1'b0;
        i_d_we    = 1'b0;
        i_d_addr  = '0;
        i_d_wdata = '0;
        ack_en    = 1'b1;
        ack_delay = 0;
        exp_err   = 1'b0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            phys_mem[i] = w;
            ref_mem[i]  = w;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset ctrl outputs", 64'({o_if_done, o_d_done, o_mem_req, o_mem_we, o_err}), 64'(0));
        check("reset data outputs", 64'(o_if_rdata | o_d_rdata | o_mem_addr | o_mem_wdata), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Lone fetch, memory acks 2 cycles after the request rises.
        phys_mem[10] = 32'h0073_2023;
        ref_mem[10]  = 32'h0073_2023;
        ack_delay = 2;
        run_txn(1'b1, 1'b0, 32'h28, 32'h0, 1'b0, 32'h0, 1'b0);
        // Simultaneous store and fetch to the same word.
        ack_delay = 1;
        run_txn(1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 32'hFEED_BEEF, 1'b0);
        // Misaligned load.
        ack_delay = 0;
        run_txn(1'b0, 1'b1, 32'h0, 32'h13, 1'b0, 32'h0, 1'b0);
        // Ack arrives in the very cycle the timeout would fire.
        ack_delay = TO - 1;
        run_txn(1'b0, 1'b1, 32'h0, 32'h84, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            kind      = int'($urandom_range(0, 2));
            ack_delay = int'($urandom_range(0, TO - 1));
            ra  = 32'($urandom_range(0, 1023));
            rb  = 32'($urandom_range(0, 1023));
            rwe = 1'($urandom_range(0, 1));
            rwd = $urandom;
            run_txn(kind != 1, kind != 0, ra, rb, rwe, rwd, 1'b0);
        end

        // Both requesters held: five grants observed.
`ifdef MEM_ARB_FAIRNESS_EN
        fair = 1'b1;
`else
        fair = 1'b0;
`endif
        exp_seq = '0;
        starve  = 0;
        for (int g = 0; g < 5; g++) begin
            if (fair && starve == SLIM) begin
                exp_seq = {exp_seq[3:0], 1'b1};
                starve  = 0;
            end else begin
                exp_seq = {exp_seq[3:0], 1'b0};
                starve++;
            end
        end
        ack_delay = 0;
        i_if_req  = 1'b1;
        i_if_addr = 32'h100;
        i_d_req   = 1'b1;
        i_d_we    = 1'b0;
        i_d_addr  = 32'h200;
        seq  = '0;
        n    = 0;
        prev = 1'b0;
        for (int cyc = 0; cyc < 100 && n < 5; cyc++) begin
            @(posedge clk);
            #1;
            if (o_mem_req && !prev) begin
                seq = {seq[3:0], o_mem_addr == 32'h100};
                n++;
                if (n == 5) begin
                    i_if_req = 1'b0;
                    i_d_req  = 1'b0;
                end
            end
            prev = o_mem_req;
        end
        check("held grant count", 64'(n), 64'(5));
        check("held grant sequence", 64'(seq), 64'(exp_seq));
        i_if_req = 1'b0;
        i_d_req  = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        exp_d_rdata = ref_mem[32'h200 >> 2];
        if (exp_seq != 5'b0) exp_if_rdata = ref_mem[32'h100 >> 2];
        check("held d rdata", 64'(o_d_rdata), 64'(exp_d_rdata));
        check("held if rdata", 64'(o_if_rdata), 64'(exp_if_rdata));
        check("idle after held", 64'(o_mem_req), 64'(0));

        // Memory never answers.
        ack_en = 1'b0;
        run_txn(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0, 1'b1);
        run_txn(1'b0, 1'b1, 32'h0, 32'h48, 1'b0, 32'h0, 1'b1);

        // Reset in the second BUSY cycle.
        i_if_req  = 1'b1;
        i_if_addr = 32'h60;
        @(posedge clk);
        #1;
        check("busy before reset", 64'(o_mem_req), 64'(1));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid reset mem_req", 64'(o_mem_req), 64'(0));
        check("mid reset err", 64'(o_err), 64'(0));
        check("mid reset ctrl", 64'({o_if_done, o_d_done, o_mem_we}), 64'(0));
        check("mid reset data", 64'(o_if_rdata | o_d_rdata | o_mem_addr | o_mem_wdata), 64'(0));
        i_if_req = 1'b0;
        @(posedge clk);
        #3;
        rst_n        = 1'b1;
        exp_err      = 1'b0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        quiet = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            quiet = quiet | o_if_done | o_d_done | o_mem_req;
        end
        check("no done after abort", 64'(quiet), 64'(0));
        ack_en    = 1'b1;
        ack_delay = 1;
        run_txn(1'b1, 1'b0, 32'h28, 32'h0, 1'b0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between two requesters of the pipelined core: instruction fetch (IF, read-only) and data load/store (D).
- Sits between the core's fetch/MEM stages and the memory.
- Each requester holds its request until it receives a one-cycle done pulse; the core stalls meanwhile.
- Includes arbitration, a per-transaction timeout and a sticky error flag.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- TIMEOUT_CYCLES, 64, maximum cycles waiting for i_mem_ack; 0 disables the timeout.
- STARVE_LIMIT, 4, consecutive D grants allowed while IF waits (used only with the optional feature).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_l  in  1  asynchronous, active-low reset.
- i_if_req  in  1  fetch request; held with i_if_addr until o_if_done.
- i_if_addr  in  ADDR_W  fetch byte address.
- o_if_done  out  1  one-cycle pulse: fetch complete.
- o_if_rdata  out  DATA_W  fetched word; valid while o_if_done is high, then held.
- i_d_req  in  1  data request; held with its address/control until o_d_done.
- i_d_we  in  1  1 = store, 0 = load.
- i_d_addr  in  ADDR_W  data byte address.
- i_d_wdata  in  DATA_W  store data.
- o_d_done  out  1  one-cycle pulse: data access complete.
- o_d_rdata  out  DATA_W  load data; valid while o_d_done is high, then held.
- o_mem_req  out  1  memory request; held until ack or timeout.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_W  word-aligned address; bits [1:0] forced to 0.
- o_mem_wdata  out  DATA_W  memory write data.
- i_mem_ack  in  1  memory completion; sampled only while o_mem_req = 1.
- i_mem_rdata  in  DATA_W  read data; valid in the ack cycle.
- o_err  out  1  sticky: a timeout has occurred; cleared only by reset.

Behaviour:
- All outputs are registered.
- Reset (i_rst_l = 0, asynchronous): state = IDLE; every output = 0, including o_mem_req, both done pulses, both rdata buses and o_err; timeout and starvation counters = 0.
- Reset asserted mid-transaction drops o_mem_req immediately; no done pulse is issued for the aborted transaction.

FSM states: IDLE, BUSY, RESP.
- IDLE: choose a winner.
  - Default: D wins over IF (strict data priority).
  - On a winner, register owner, we, addr and wdata; go to BUSY.
  - IF grants always drive we = 0.
  - With no request, stay in IDLE.
- BUSY:
  - o_mem_req = 1 with the registered command, stable for the whole state.
  - On i_mem_ack = 1: capture i_mem_rdata into the owner's rdata register (loads and fetches only; stores leave rdata unchanged); drop o_mem_req; go to RESP.
  - Timeout counter increments each BUSY cycle without ack.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: drop o_mem_req; set o_err; load the owner's rdata with 32'h0000_0013 for IF (nop) or 0 for D; go to RESP.
  - An ack in the same cycle as the timeout wins: normal completion, o_err not set.
- RESP:
  - The owner's done signal = 1 for exactly this cycle.
  - Next state is IDLE; no arbitration occurs in RESP, so a request being dropped is never re-granted.

Latency and throughput:
- Request seen in IDLE at cycle N; o_mem_req high from N+1.
- Ack at cycle N+1+k gives done at cycle N+2+k.
- Minimum of 3 cycles per transaction.
- The loser's request stays pending and is granted at the next IDLE.

Other rules:
- Requests changing while not granted are ignored; only the value sampled in IDLE matters.
- i_mem_ack outside BUSY is ignored.

Optional Feature:
- Macro: MEM_ARB_FAIRNESS_EN.
- Defined: a starvation counter increments on each D grant made while i_if_req = 1.
  - When the counter equals STARVE_LIMIT, the next IDLE with both requesting grants IF.
  - The counter clears on any IF grant, or whenever i_if_req = 0 in IDLE.
- Undefined: strict D priority; the counter logic is absent.

Test Plan:
- Reset, then a lone IF read at 0x28 with the memory acking 2 cycles after o_mem_req rises, returning 32'h0073_2023 → o_mem_addr = 0x28, o_mem_we = 0; o_if_done pulses once 3 cycles after o_mem_req first rises, with o_if_rdata = 32'h0073_2023.
- IF and D requests in the same cycle, D a store of 32'hFEED_BEEF to 0x0 → D granted first (o_mem_we = 1, wdata FEEDBEEF); IF granted at the following IDLE; each done pulses exactly once.
- Memory never acks with TIMEOUT_CYCLES = 8 → o_mem_req drops after 8 BUSY cycles; done pulses with rdata 0x13 (IF) or 0 (D); o_err = 1 and stays high.
- Misaligned D load at 0x13 → o_mem_addr = 0x10.
- Reset pulled low on the 2nd BUSY cycle → o_mem_req and all outputs go to 0 asynchronously; no done pulse; after release the arbiter is in IDLE.
- With MEM_ARB_FAIRNESS_EN and STARVE_LIMIT = 4: D and IF requests held continuously → grant sequence D, D, D, D, IF. Without the macro, IF is never granted while D is held.
